// File: rtl/color_manager_sync_gen.sv
// color_manager_sync_gen: line/frame timing source with a frame-boundary shadowed configuration
module color_manager_sync_gen #(
  parameter int BACKPORCH_WIDTH = 8,
  parameter int FRONTPORCH_WIDTH = 10,
  parameter int BLANK_WIDTH = 8,
  parameter int LINE_WIDTH = 10
) (
  input  logic                        Clk,
  input  logic                        rst,
  input  logic                        Enable,
  input  logic                        Cfg_Load,
  input  logic [BACKPORCH_WIDTH-1:0]  Cfg_BackPorch,
  input  logic [FRONTPORCH_WIDTH-1:0] Cfg_FrontPorch,
  input  logic [FRONTPORCH_WIDTH-1:0] Cfg_LineLen,
  input  logic [BLANK_WIDTH-1:0]      Cfg_Blank,
  input  logic [LINE_WIDTH-1:0]       Cfg_Lines,
  output logic                        Sync,
  output logic [BACKPORCH_WIDTH-1:0]  BackPorch,
  output logic [FRONTPORCH_WIDTH-1:0] FrontPorch,
  output logic                        Line_Start,
  output logic                        Frame_Start,
  output logic [LINE_WIDTH-1:0]       Line_Index,
  output logic                        Cfg_Valid,
  output logic                        Cfg_Err,
  output logic                        Busy
);
  localparam int CW = FRONTPORCH_WIDTH + 1;
  typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_t;
  typedef struct packed {
    logic [BACKPORCH_WIDTH-1:0]  bp;
    logic [FRONTPORCH_WIDTH-1:0] fp;
    logic [FRONTPORCH_WIDTH-1:0] len;
    logic [BLANK_WIDTH-1:0]      blank;
    logic [LINE_WIDTH-1:0]       lines;
  } cfg_t;
  state_t state, next_state;
  cfg_t req, app, pend;
  logic pend_valid;
  logic [FRONTPORCH_WIDTH-1:0] pos;
  logic [BLANK_WIDTH-1:0] bcnt;
  logic [LINE_WIDTH-1:0] next_line;
  logic [CW-1:0] bp_x, fp_x, len_x;
  logic cfg_ok, load_ok, line_end, blank_end, last_line, frame_entry;
  assign req = {Cfg_BackPorch, Cfg_FrontPorch, Cfg_LineLen, Cfg_Blank, Cfg_Lines};
  assign bp_x = CW'(Cfg_BackPorch);
  assign fp_x = CW'(Cfg_FrontPorch);
  assign len_x = CW'(Cfg_LineLen);
  assign cfg_ok = |Cfg_LineLen && |Cfg_Blank && |Cfg_Lines && bp_x + CW'(1) < fp_x && fp_x <= len_x;
  assign load_ok = Cfg_Load && cfg_ok;
  assign line_end = state == ACTIVE && pos == app.len - FRONTPORCH_WIDTH'(1);
  assign blank_end = state == BLANK && bcnt == app.blank - BLANK_WIDTH'(1);
  assign last_line = Line_Index == app.lines - LINE_WIDTH'(1);
  assign frame_entry = (state == IDLE && Enable && Cfg_Valid) || (blank_end && Enable && last_line);
  assign next_line = blank_end && Enable && !last_line ? Line_Index + LINE_WIDTH'(1) :
                     (state == ACTIVE || (state == BLANK && !blank_end)) ? Line_Index : '0;
  assign BackPorch = app.bp;
  assign FrontPorch = app.fp;
  always_ff @(posedge Clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end
  always_comb begin
    next_state = state == IDLE   ? (Enable && Cfg_Valid ? ACTIVE : IDLE) :
                 state == ACTIVE ? (line_end ? BLANK : ACTIVE) :
                 state == BLANK  ? (blank_end ? (Enable ? ACTIVE : IDLE) : BLANK) : IDLE;
  end
  always_comb begin
    Sync = state == ACTIVE;
    Line_Start = state == ACTIVE && pos == '0;
    Frame_Start = Line_Start && Line_Index == '0;
    Busy = state != IDLE;
  end
  always_ff @(posedge Clk) begin
    if (rst) begin
      pos <= '0;
      bcnt <= '0;
      Line_Index <= '0;
      Cfg_Err <= 1'b0;
      Cfg_Valid <= 1'b0;
      app <= '0;
      pend <= '0;
      pend_valid <= 1'b0;
    end else begin
      pos <= state == ACTIVE && !line_end ? pos + FRONTPORCH_WIDTH'(1) : '0;
      bcnt <= state == BLANK && !blank_end ? bcnt + BLANK_WIDTH'(1) : '0;
      Line_Index <= next_line;
      Cfg_Err <= Cfg_Load && !cfg_ok;
      if (load_ok && state == IDLE) begin
        app <= req;
        Cfg_Valid <= 1'b1;
        pend_valid <= 1'b0;
      end else if (load_ok) begin
        pend <= req;
        pend_valid <= 1'b1;
        if (frame_entry && pend_valid)
          app <= pend;
      end else if (frame_entry && pend_valid) begin
        app <= pend;
        pend_valid <= 1'b0;
      end
    end
  end
endmodule
